// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decode-side hazard information into the controller and
// the control signals it returns to fetch, decode and execute.
//   master : the hazard controller (consumes decode info, drives controls)
//   slave  : the pipeline side (drives decode info, consumes controls)
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned RA_W = 5;

  logic            idValid;
  logic [RA_W-1:0] idRs1Addr;
  logic [RA_W-1:0] idRs2Addr;
  logic            idRs1Used;
  logic            idRs2Used;
  logic [RA_W-1:0] idRdAddr;
  logic            idRdWrite;
  logic            idIsLoad;
  logic            exBrTaken;

  logic [1:0]       op1BypassCtrl;
  logic [1:0]       op2BypassCtrl;
  logic             stallIF;
  logic             stallID;
  logic             flushID;
  logic             bubbleEX;
  logic [CNT_W-1:0] stallCycles;

  modport master (
    input  idValid, idRs1Addr, idRs2Addr, idRs1Used, idRs2Used,
           idRdAddr, idRdWrite, idIsLoad, exBrTaken,
    output op1BypassCtrl, op2BypassCtrl, stallIF, stallID, flushID,
           bubbleEX, stallCycles
  );

  modport slave (
    output idValid, idRs1Addr, idRs2Addr, idRs1Used, idRs2Used,
           idRdAddr, idRdWrite, idIsLoad, exBrTaken,
    input  op1BypassCtrl, op2BypassCtrl, stallIF, stallID, flushID,
           bubbleEX, stallCycles
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard control beside the decode stage.
// Tracks in-flight destinations in a two-slot scoreboard (EX, MEM), produces
// operand bypass selects, load-use / interlock stalls and the post-branch flush.
// Ports:
//   clk  - pipeline clock; state updates on the falling edge like the pipe regs
//   rst  - asynchronous reset, active low
//   bus  - hazard_controller_if.master (decode info in, control outputs out)
// Build option: define HAZARD_BYPASS_EN to enable operand forwarding (only
// load-use then stalls); without it every dependency interlocks until the
// producer has left MEM and both selects stay BYPASS_NONE.
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_controller_if.master bus
);
  localparam int unsigned RA_W = 5;
  localparam int unsigned FC_W = 3;
  localparam logic [FC_W-1:0] FLUSH_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [1:0]      BYPASS_NONE = 2'd0;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            rd_write;
    logic            is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  sb_entry_t        ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       ex_m1, ex_m2, mem_m1, mem_m2;
  logic       hazard_c, flush_go_c, flush_c, stall_c, issue_c;
  logic [1:0] op1_sel_c, op2_sel_c;

  // A used, non-x0 source depends on a valid writing slot with the same rd.
  function automatic logic slot_match(input sb_entry_t s, input logic [RA_W-1:0] src,
                                      input logic used);
    return s.valid && s.rd_write && (s.rd != '0) && (s.rd == src) && used;
  endfunction

  assign ex_m1  = slot_match(ex_q,  bus.idRs1Addr, bus.idRs1Used);
  assign ex_m2  = slot_match(ex_q,  bus.idRs2Addr, bus.idRs2Used);
  assign mem_m1 = slot_match(mem_q, bus.idRs1Addr, bus.idRs1Used);
  assign mem_m2 = slot_match(mem_q, bus.idRs2Addr, bus.idRs2Used);

`ifdef HAZARD_BYPASS_EN
  localparam logic [1:0] BYPASS_EXEC = 2'd1;
  localparam logic [1:0] BYPASS_MEM  = 2'd2;

  // Only a load still in EX cannot be forwarded in time.
  assign hazard_c = bus.idValid && (ex_m1 || ex_m2) && ex_q.is_load;

  // EX slot is younger, so it wins over MEM.
  always_comb begin
    op1_sel_c = BYPASS_NONE;
    op2_sel_c = BYPASS_NONE;
    if (ex_m1)       op1_sel_c = BYPASS_EXEC;
    else if (mem_m1) op1_sel_c = BYPASS_MEM;
    if (ex_m2)       op2_sel_c = BYPASS_EXEC;
    else if (mem_m2) op2_sel_c = BYPASS_MEM;
  end
`else
  // No forwarding: wait until the producer has written the register file.
  assign hazard_c  = bus.idValid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
  assign op1_sel_c = BYPASS_NONE;
  assign op2_sel_c = BYPASS_NONE;
`endif

  // A bubble in EX cannot redirect the PC, so its exBrTaken is ignored.
  assign flush_go_c = bus.exBrTaken && ex_q.valid;
  assign flush_c    = flush_go_c || (state_q == ST_FLUSH);
  assign stall_c    = hazard_c && !flush_c;
  assign issue_c    = bus.idValid && !stall_c && !flush_c;

  // Scoreboard shift and saturating stall counter.
  always_comb begin
    ex_d = '0;
    if (issue_c) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = bus.idRdAddr;
      ex_d.rd_write = bus.idRdWrite;
      ex_d.is_load  = bus.idIsLoad;
    end
    mem_d       = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Next state. The branch cycle itself is the first bubble, so FLUSH
  // holds for FLUSH_CYCLES-1 further cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_FLUSH: begin
        fcnt_d  = (fcnt_q != '0) ? fcnt_q - FC_W'(1) : '0;
        state_d = (fcnt_q <= FC_W'(1)) ? ST_RUN : ST_FLUSH;
      end
      default: state_d = stall_c ? ST_STALL : ST_RUN;
    endcase
    if (flush_go_c) begin
      fcnt_d  = FLUSH_LOAD;
      state_d = (FLUSH_LOAD == '0) ? ST_RUN : ST_FLUSH;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.op1BypassCtrl = op1_sel_c;
  assign bus.op2BypassCtrl = op2_sel_c;
  assign bus.stallIF       = stall_c;
  assign bus.stallID       = stall_c;
  assign bus.flushID       = flush_c;
  assign bus.bubbleEX      = flush_c || stall_c;
  assign bus.stallCycles   = stall_cnt_q;

  // The MEM slot's load flag (and EX's without forwarding) is kept for
  // scoreboard completeness but not consulted.
  logic unused_sb;
  assign unused_sb = ^{ex_q.is_load, mem_q.is_load};
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Output vector layout used in checks:
// {op1[1:0], op2[1:0], stallIF, stallID, flushID, bubbleEX}.
module tb_hazard_controller;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_stalls = 0;
  logic [7:0] o;

  hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_controller #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.op1BypassCtrl, bus.op2BypassCtrl, bus.stallIF, bus.stallID,
            bus.flushID, bus.bubbleEX};
  endfunction

  // Drive the decode stage (and exBrTaken) mid-cycle, then let outputs settle.
  task automatic id(input logic v, input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                    input logic w, input logic ld, input logic br);
    bus.idValid   = v;
    bus.idRs1Addr = rs1;
    bus.idRs1Used = u1;
    bus.idRs2Addr = rs2;
    bus.idRs2Used = u2;
    bus.idRdAddr  = rd;
    bus.idRdWrite = w;
    bus.idIsLoad  = ld;
    bus.exBrTaken = br;
    #1;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One pipeline cycle: state updates on the falling edge.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL reset_outs: got=%b exp=%b", o, 8'b0); end
    checks++;
    if (bus.stallCycles !== 8'd0) begin errors++; $display("FAIL reset_cnt: got=%0d exp=0", bus.stallCycles); end
    rst = 1'b1;
    #1;
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL reset_release_outs: got=%b exp=%b", o, 8'b0); end
    drain();
    checks++;
    if (bus.stallCycles !== 8'd0) begin errors++; $display("FAIL reset_idle_cnt: got=%0d exp=0", bus.stallCycles); end
  endtask

  task automatic test_x0_and_no_dep();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);  // writes x0
    cyc();
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);  // reads x0
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL x0_ex: got=%b exp=%b", o, 8'b0); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL x0_next: got=%b exp=%b", o, 8'b0); end
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);  // rd x9, no write
    cyc();
    id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL nowrite: got=%b exp=%b", o, 8'b0); end
    cyc();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    cyc();
    id(1'b1, 5'd11, 1'b0, 5'd11, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);  // sources unused
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL unused_src: got=%b exp=%b", o, 8'b0); end
    cyc();
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL x0_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  task automatic test_alu_use();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);  // add x5
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL alu_prod: got=%b exp=%b", o, 8'b0); end
    cyc();
    id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);  // add x6,x5,x5
    o = outs();
`ifdef HAZARD_BYPASS_EN
    checks++;
    if (o !== 8'b0101_0000) begin errors++; $display("FAIL alu_exec: got=%b exp=%b", o, 8'b0101_0000); end
    cyc();
`else
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL alu_stall1: got=%b exp=%b", o, 8'b0000_1101); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL alu_stall2: got=%b exp=%b", o, 8'b0000_1101); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL alu_release: got=%b exp=%b", o, 8'b0); end
    cyc();
    exp_stalls += 2;
`endif
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL alu_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
    // One independent instruction between producer and consumer.
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL gap_indep: got=%b exp=%b", o, 8'b0); end
    cyc();
    id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);  // add x6,x1,x5
    o = outs();
`ifdef HAZARD_BYPASS_EN
    checks++;
    if (o !== 8'b0010_0000) begin errors++; $display("FAIL gap_mem: got=%b exp=%b", o, 8'b0010_0000); end
    cyc();
`else
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL gap_stall: got=%b exp=%b", o, 8'b0000_1101); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL gap_release: got=%b exp=%b", o, 8'b0); end
    cyc();
    exp_stalls += 1;
`endif
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL gap_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  task automatic test_load_use();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);  // lw x7
    cyc();
    id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);  // add x8,x7,x0
    o = outs();
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL lu_stall: got=%b exp=%b", o, 8'b0000_1101); end
    cyc();
    o = outs();
`ifdef HAZARD_BYPASS_EN
    checks++;
    if (o !== 8'b1000_0000) begin errors++; $display("FAIL lu_mem: got=%b exp=%b", o, 8'b1000_0000); end
    cyc();
    exp_stalls += 1;
`else
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL lu_stall2: got=%b exp=%b", o, 8'b0000_1101); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL lu_release: got=%b exp=%b", o, 8'b0); end
    cyc();
    exp_stalls += 2;
`endif
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL lu_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  task automatic test_flush();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // branch carrier
    cyc();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    o = outs();
    checks++;
    if (o !== 8'b0000_0011) begin errors++; $display("FAIL flush_c0: got=%b exp=%b", o, 8'b0000_0011); end
    cyc();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    o = outs();
    checks++;
    if (o !== 8'b0000_0011) begin errors++; $display("FAIL flush_c1: got=%b exp=%b", o, 8'b0000_0011); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL flush_end: got=%b exp=%b", o, 8'b0); end
    cyc();
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL flush_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  task automatic test_flush_over_hazard();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);  // lw x7 (branch slot valid)
    cyc();
    id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);  // load-use + branch
    o = outs();
    checks++;
    if (o[3:0] !== 4'b0011) begin errors++; $display("FAIL fh_c0: got=%b exp=%b", o[3:0], 4'b0011); end
    cyc();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    o = outs();
    checks++;
    if (o !== 8'b0000_0011) begin errors++; $display("FAIL fh_c1: got=%b exp=%b", o, 8'b0000_0011); end
    cyc();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL fh_end: got=%b exp=%b", o, 8'b0); end
    cyc();
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL fh_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  task automatic test_branch_bubble_ignored();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL bri_c0: got=%b exp=%b", o, 8'b0); end
    cyc();
    nop();
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL bri_c1: got=%b exp=%b", o, 8'b0); end
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);  // lw x7
    cyc();
    id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    o = outs();
    checks++;
    if (o !== 8'b0000_1101) begin errors++; $display("FAIL rms_stall: got=%b exp=%b", o, 8'b0000_1101); end
    rst = 1'b0;
    #1;
    exp_stalls = 0;
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL rms_outs: got=%b exp=%b", o, 8'b0); end
    checks++;
    if (bus.stallCycles !== 8'd0) begin errors++; $display("FAIL rms_cnt: got=%0d exp=0", bus.stallCycles); end
    cyc();
    rst = 1'b1;
    #1;
    o = outs();
    checks++;
    if (o !== 8'b0) begin errors++; $display("FAIL rms_after: got=%b exp=%b", o, 8'b0); end
    cyc();
  endtask

  task automatic test_stall_saturation();
`ifdef HAZARD_BYPASS_EN
    localparam int PER = 1;
    localparam int N   = 270;
`else
    localparam int PER = 2;
    localparam int N   = 140;
`endif
    drain();
    for (int i = 0; i < N; i++) begin
      id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      cyc();
      id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      repeat (PER + 1) cyc();
    end
    exp_stalls = (exp_stalls + PER * N > 255) ? 255 : exp_stalls + PER * N;
    nop();
    checks++;
    if (bus.stallCycles !== 8'(exp_stalls)) begin errors++; $display("FAIL sat_cnt: got=%0d exp=%0d", bus.stallCycles, exp_stalls); end
  endtask

  initial begin
    nop();
    test_reset();
    test_x0_and_no_dep();
    test_alu_use();
    test_load_use();
    test_flush();
    test_flush_over_hazard();
    test_branch_bubble_ignored();
    test_reset_mid_stall();
    test_stall_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central pipeline controller for the decode→execute→memory datapath. It tracks destination registers of in-flight instructions in an internal scoreboard and drives operand bypass selects into the decode pipe register. It generates load-use and interlock stalls, and sequences the flush after a taken branch/jump resolved in execute. It sits beside the decode stage and feeds the ControllerIF signals consumed by fetch, decode and execute.

## Interface
Parameters:
- FLUSH_CYCLES, 2: bubbles inserted after a taken branch (1..7).
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers.
- rst  in  1  asynchronous, active-low reset.
- idValid  in  1  decode stage holds a real instruction.
- idRs1Addr, idRs2Addr  in  5 each  source register numbers.
- idRs1Used, idRs2Used  in  1 each  source operand actually read.
- idRdAddr  in  5  destination register.
- idRdWrite  in  1  instruction writes rd.
- idIsLoad  in  1  instruction is a load.
- exBrTaken  in  1  execute resolved irregular PC (taken branch/jump) this cycle.
- op1BypassCtrl, op2BypassCtrl  out  2 each  0=BYPASS_NONE, 1=BYPASS_EXEC, 2=BYPASS_MEM.
- stallIF, stallID  out  1 each  hold fetch PC / decode pipe register.
- flushID  out  1  invalidate decode-stage instruction.
- bubbleEX  out  1  decode pipe register loads a NOP into execute.
- stallCycles  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard: two slots, EX and MEM. Each slot holds {valid, rd, rdWrite, isLoad}.
  - Each clock: MEM←EX.
  - EX←the decode instruction if it issues, else an invalid entry.
  - An instruction issues when idValid=1, stallID=0, flushID=0.
- Match rule: a source matches a slot if the slot is valid, rdWrite=1, rd≠0, rd==source addr, and the source is used. The EX slot has priority over MEM.
- Bypass selects are combinational for the current decode instruction:
  - EX match → BYPASS_EXEC.
  - else MEM match → BYPASS_MEM.
  - else NONE.
  - Selects are captured with the instruction by the decode pipe register.
- Load-use: EX-slot match with isLoad=1 → stallIF=stallID=bubbleEX=1 for one cycle. The next cycle the producer is in MEM and BYPASS_MEM applies.
- FSM states RUN, STALL, FLUSH:
  - RUN→STALL on a hazard.
  - STALL→RUN when the hazard clears (re-evaluated every cycle).
  - Any state→FLUSH when exBrTaken=1 and the EX slot is valid. The counter loads FLUSH_CYCLES-1.
  - FLUSH: flushID=bubbleEX=1, stalls 0. Decrement each cycle; →RUN when the counter is 0.
- exBrTaken while the EX slot is invalid (bubble) is ignored.
- stallCycles increments on every cycle with stallID=1 and saturates at all-ones.

## Timing
- Reset values: scoreboard invalid, state RUN, counter 0, stallCycles 0. All outputs 0 / BYPASS_NONE.
- Reset asserted mid-STALL/FLUSH returns to RUN immediately. No pending flush survives reset.
- Outputs are combinational from state plus decode inputs, and valid in the same cycle. No output latency.
- exBrTaken and a hazard in the same cycle: flush wins. stallIF/stallID=0, the hazard instruction is discarded, and stallCycles does not count that cycle.
- Load-use costs exactly 1 stall cycle. Taken branch costs exactly FLUSH_CYCLES bubble cycles.
- x0 never creates a dependency.

## Configuration
- HAZARD_BYPASS_EN defined: forwarding as above; only load-use stalls.
- Undefined:
  - Both bypass selects are tied to BYPASS_NONE.
  - Any EX- or MEM-slot match stalls until the producer has left MEM; the register file is write-first.
  - Load-use stalls up to 2 cycles; ALU-use up to 2 cycles.
  - FLUSH behaviour is unchanged.

## Test plan
- Reset with idValid=1 and no producers → all selects NONE, no stall, stallCycles=0.
- addi x5 then add x6,x5,x5 (HAZARD_BYPASS_EN) → op1/op2=BYPASS_EXEC, no stall. With one independent op in between → BYPASS_MEM.
- lw x7 then add x8,x7,x0 → one cycle stallIF=stallID=bubbleEX=1, then op1=BYPASS_MEM, stallCycles=1.
- exBrTaken=1 with a valid EX slot, FLUSH_CYCLES=2 → flushID=bubbleEX=1 for exactly 2 cycles, then RUN. The same cycle as a load-use hazard → no stall, flush only.
- Producer writing x0 followed by a consumer of x0 → NONE, no stall.
- HAZARD_BYPASS_EN undefined, add x5 then use x5 → 2 stall cycles, selects NONE, stallCycles=2. rst low during a stall → all outputs 0 immediately.
